maxpool_2x2: RTL

- Streaming 2x2 max-pooling stage with stride 2, placed directly downstream of the convolution stage.
- Consumes one WORD_SIZE pixel per valid cycle in raster order and emits one pooled pixel per 2x2 window.
- Halves both image dimensions before the next CNN layer.
- Buffers one half-width row of partial maxima internally.

---
 rtl/maxpool_2x2_if.sv | 25 ++
 rtl/maxpool_2x2.sv | 127 ++++++++++++
 2 files changed

// File: rtl/maxpool_2x2_if.sv
// Pixel stream into, and pooled pixel stream out of, the 2x2 max-pool stage.
// Latency: none (wiring only).
// Backpressure: none; the stage accepts every valid pixel, the consumer must take every pooled pixel.
interface maxpool_2x2_if #(
  parameter int WORD_SIZE = 8
);
  logic [WORD_SIZE-1:0] inputPixel;
  logic                 inputValid;
  logic                 startOfFrame;
  logic [WORD_SIZE-1:0] outputPixel;
  logic                 outputValid;
  logic                 frameDone;

  // Producer side: convolution stage feeding pixels, observing pooled output.
  modport master (
    output inputPixel, inputValid, startOfFrame,
    input  outputPixel, outputValid, frameDone
  );

  // Pooling stage side.
  modport slave (
    input  inputPixel, inputValid, startOfFrame,
    output outputPixel, outputValid, frameDone
  );
endinterface

// File: rtl/maxpool_2x2.sv
// Streaming 2x2 / stride-2 max-pool over a raster-order pixel stream, one half-width row of partial maxima buffered.
// Latency: pooled pixel appears 1 clock after the edge accepting the window's bottom-right pixel.
// Backpressure: none; every valid pixel is consumed, idle cycles freeze all state.
module maxpool_2x2 #(
  parameter int WORD_SIZE    = 8,
  parameter int ROW_SIZE     = 540,
  parameter int IMAGE_HEIGHT = 360
) (
  input logic          clk,
  input logic          rst,
  maxpool_2x2_if.slave bus
);

  localparam int COL_W  = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int ROW_W  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int HALF_W = ROW_SIZE / 2;
  localparam int LB_AW  = (HALF_W > 1) ? $clog2(HALF_W + 1) : 1;

  localparam logic [COL_W-1:0] COL_LAST     = COL_W'(ROW_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [COL_W-1:0] WIN_COL_LAST = COL_W'(2 * HALF_W - 1);
  localparam logic [ROW_W-1:0] WIN_ROW_LAST = ROW_W'(2 * (IMAGE_HEIGHT / 2) - 1);
  localparam bit               ODD_COLS     = (ROW_SIZE % 2) != 0;

  // Position of the pixel currently in flight, hold register and line buffer.
  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  logic [WORD_SIZE-1:0] hreg;
  logic [WORD_SIZE-1:0] lbuf [HALF_W];

  // Registered output stage.
  logic [WORD_SIZE-1:0] out_pixel;
  logic                 out_valid;
  logic                 frame_done;

  // Combinational decode of the accepted pixel.
  logic                 accept;
  logic [COL_W-1:0]     cur_col;
  logic [ROW_W-1:0]     cur_row;
  logic                 at_col_last;
  logic                 at_row_last;
  logic                 col_odd;
  logic                 row_odd;
  logic                 skip_col;
  logic [LB_AW-1:0]     lb_idx;
  logic [WORD_SIZE-1:0] lb_rd;
  logic [WORD_SIZE-1:0] pair_max;
  logic [WORD_SIZE-1:0] win_max;
  logic                 hreg_we;
  logic                 lbuf_we;
  logic                 emit;
  logic                 emit_last;

  // Decode where this pixel sits; startOfFrame pins it to (0,0) whatever the counters say.
  always_comb begin
    accept      = bus.inputValid;
    cur_col     = (bus.inputValid && bus.startOfFrame) ? '0 : col;
    cur_row     = (bus.inputValid && bus.startOfFrame) ? '0 : row;
    at_col_last = (cur_col == COL_LAST);
    at_row_last = (cur_row == ROW_LAST);
    col_odd     = cur_col[0];
    row_odd     = cur_row[0];
    // With an odd row width the final even column has no partner and is dropped.
    skip_col    = ODD_COLS && at_col_last;
    lb_idx      = LB_AW'(cur_col >> 1);
    lb_rd       = lbuf[lb_idx];
    pair_max    = (hreg > bus.inputPixel) ? hreg : bus.inputPixel;
    win_max     = (lb_rd > pair_max) ? lb_rd : pair_max;
    hreg_we     = accept && !col_odd && !skip_col;
    lbuf_we     = accept && !row_odd && col_odd;
    // An odd row index is always inside a full window row; a trailing odd-height row has an even index.
    emit        = accept && row_odd && col_odd;
    emit_last   = emit && (cur_row == WIN_ROW_LAST) && (cur_col == WIN_COL_LAST);
  end

  // Column/row counters advance only on accepted pixels and wrap at frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (at_col_last) begin
        col <= '0;
        row <= at_row_last ? '0 : cur_row + ROW_W'(1);
      end else begin
        col <= cur_col + COL_W'(1);
        row <= cur_row;
      end
    end
  end

  // Hold the left pixel of each horizontal pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hreg <= '0;
    end else if (hreg_we) begin
      hreg <= bus.inputPixel;
    end
  end

  // Even rows park their pair maxima; each entry is rewritten before the odd row reads it, so no reset.
  always_ff @(posedge clk) begin
    if (lbuf_we) begin
      lbuf[lb_idx] <= pair_max;
    end
  end

  // Output register: pooled value and pulses for one cycle per completed window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pixel  <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= emit;
      frame_done <= emit_last;
      if (emit) begin
        out_pixel <= win_max;
      end
    end
  end

  assign bus.outputPixel = out_pixel;
  assign bus.outputValid = out_valid;
  assign bus.frameDone   = frame_done;

endmodule
